// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-channel memory bus arbiter.
// No logic here; latency and backpressure are defined by the modules that use it.
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_TIMEOUT = 64;

    // Index width for n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational winner pick: fixed priority from index 0, or round-robin from ptr.
// Zero latency; channels set in excl are never selected.
module rr_prio_select
    import mem_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    input  logic           rr_mode,
    input  logic [NCH-1:0] excl,
    output logic [IW-1:0]  winner,
    output logic           found
);

    logic [NCH-1:0] cand;
    logic [IW-1:0]  start;

    assign cand  = req & ~excl;
    // Fixed priority is a round-robin scan that always starts at channel 0.
    assign start = rr_mode ? ptr : '0;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && cand[(int'(start) + k) % NCH]) begin
                found  = 1'b1;
                winner = IW'((int'(start) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter_nch.sv
// Grants one of NCH requesters the RAM port and muxes its address/data/r_wb onto it.
// ack/ram_valid registered at the edge req is seen; owners are pre-empted on timeout only under contention.
module mem_bus_arbiter_nch
    import mem_arb_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int AW          = 12,
    parameter int DW          = 8,
    parameter int TW          = 8,
    parameter int DEF_TIMEOUT = mem_arb_pkg::DEF_TIMEOUT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cfg_timeout_we,
    input  logic [TW-1:0]                 cfg_timeout,
    input  logic                          cfg_rr_mode,
    input  logic [NCH-1:0]                req,
    input  logic [NCH-1:0]                r_wb_proc,
    input  logic [NCH*AW-1:0]             addbus_proc,
    input  logic [NCH*DW-1:0]             datawritebus_proc,
    output logic [NCH-1:0]                ack,
    output logic [clog2_min1(NCH)-1:0]    grant_id,
    output logic                          ram_valid,
    output logic                          r_wb_ram,
    output logic [AW-1:0]                 addbus_ram,
    output logic [DW-1:0]                 datawritebus_ram,
    output logic                          timeout_pulse
);

    localparam int IW = clog2_min1(NCH);

    arb_state_t     state;
    logic [TW-1:0]  tmo_reg;
    logic [TW-1:0]  cnt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  win_id;
    logic [IW-1:0]  next_ptr;
    logic           win_found;
    logic [NCH-1:0] owner_mask;
    logic [NCH-1:0] excl;
    logic           owner_req;
    logic           tmo_hit;
    logic           grant_now;

    assign owner_mask = NCH'(1) << grant_id;
    assign owner_req  = |(req & owner_mask);
    // The owner never competes against itself: a pre-emption must hand over.
    assign excl       = (state == GRANT) ? owner_mask : '0;
    assign tmo_hit    = (tmo_reg != '0) &&
                        (({1'b0, cnt} + (TW+1)'(1)) >= {1'b0, tmo_reg});
    assign next_ptr   = (int'(win_id) == NCH - 1) ? '0 : win_id + IW'(1);
    assign grant_now  = win_found && ((state == IDLE) || !owner_req || tmo_hit);

    rr_prio_select #(
        .NCH (NCH),
        .IW  (IW)
    ) u_select (
        .req     (req),
        .ptr     (rr_ptr),
        .rr_mode (cfg_rr_mode),
        .excl    (excl),
        .winner  (win_id),
        .found   (win_found)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ack           <= '0;
            grant_id      <= '0;
            ram_valid     <= 1'b0;
            timeout_pulse <= 1'b0;
            tmo_reg       <= TW'(DEF_TIMEOUT);
            cnt           <= '0;
            rr_ptr        <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            if (cfg_timeout_we) tmo_reg <= cfg_timeout;

            if (grant_now) begin
                state         <= GRANT;
                ack           <= NCH'(1) << win_id;
                grant_id      <= win_id;
                ram_valid     <= 1'b1;
                rr_ptr        <= next_ptr;
                cnt           <= '0;
                // A handover while the owner still requests can only be a timeout.
                timeout_pulse <= (state == GRANT) && owner_req;
            end else if (state == GRANT) begin
                if (!owner_req) begin
                    state     <= IDLE;
                    ack       <= '0;
                    ram_valid <= 1'b0;
                    cnt       <= '0;
                end else if (tmo_hit) begin
                    cnt <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + TW'(1);
                end
            end
        end
    end

    always_comb begin
        r_wb_ram         = 1'b0;
        addbus_ram       = '0;
        datawritebus_ram = '0;
        if (ram_valid) begin
            r_wb_ram         = r_wb_proc[grant_id];
            addbus_ram       = addbus_proc[int'(grant_id)*AW +: AW];
            datawritebus_ram = datawritebus_proc[int'(grant_id)*DW +: DW];
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter_nch.sv
// Scoreboard bench for mem_bus_arbiter_nch: expected bus state queued per cycle, checked 1 time unit after each edge.
module tb_mem_bus_arbiter_nch;

    localparam int NCH = 4;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int TW  = 8;

    logic                 clock;
    logic                 reset;
    logic                 cfg_timeout_we;
    logic [TW-1:0]        cfg_timeout;
    logic                 cfg_rr_mode;
    logic [NCH-1:0]       req;
    logic [NCH-1:0]       r_wb_proc;
    logic [NCH*AW-1:0]    addbus_proc;
    logic [NCH*DW-1:0]    datawritebus_proc;
    logic [NCH-1:0]       ack;
    logic [1:0]           grant_id;
    logic                 ram_valid;
    logic                 r_wb_ram;
    logic [AW-1:0]        addbus_ram;
    logic [DW-1:0]        datawritebus_ram;
    logic                 timeout_pulse;

    typedef struct packed {
        logic [NCH-1:0] ack;
        logic           vld;
        logic           pulse;
        logic [1:0]     gid;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  dat;
        logic           rw;
    } obs_t;

    obs_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    mem_bus_arbiter_nch #(
        .NCH (NCH), .AW (AW), .DW (DW), .TW (TW), .DEF_TIMEOUT (64)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cfg_timeout_we    (cfg_timeout_we),
        .cfg_timeout       (cfg_timeout),
        .cfg_rr_mode       (cfg_rr_mode),
        .req               (req),
        .r_wb_proc         (r_wb_proc),
        .addbus_proc       (addbus_proc),
        .datawritebus_proc (datawritebus_proc),
        .ack               (ack),
        .grant_id          (grant_id),
        .ram_valid         (ram_valid),
        .r_wb_ram          (r_wb_ram),
        .addbus_ram        (addbus_ram),
        .datawritebus_ram  (datawritebus_ram),
        .timeout_pulse     (timeout_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [AW-1:0] ch_addr(int ch);
        return AW'(32'hA01 + ch * 17);
    endfunction

    function automatic logic [DW-1:0] ch_dat(int ch);
        return DW'(32'h50 + ch * 3);
    endfunction

    // ch < 0 means no owner: everything idle and zero.
    function automatic obs_t mk_exp(int ch, logic pulse);
        obs_t e;
        e = '0;
        e.pulse = pulse;
        if (ch >= 0) begin
            e.ack  = NCH'(1) << ch;
            e.vld  = 1'b1;
            e.gid  = 2'(ch);
            e.addr = ch_addr(ch);
            e.dat  = ch_dat(ch);
            e.rw   = (ch % 2) == 1;
        end
        return e;
    endfunction

    function automatic obs_t obs_now();
        obs_t o;
        o.ack   = ack;
        o.vld   = ram_valid;
        o.pulse = timeout_pulse;
        o.gid   = ram_valid ? grant_id : 2'd0;
        o.addr  = addbus_ram;
        o.dat   = datawritebus_ram;
        o.rw    = r_wb_ram;
        return o;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        reset = 1'b1;
        @(posedge clock); #1;
        got = obs_now();
        checks++;
        if (got !== mk_exp(-1, 1'b0) || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%h gid=%0d exp=%h gid=0", got, grant_id, mk_exp(-1, 1'b0));
        end
        reset = 1'b0;
        sbq.push_back(mk_exp(-1, 1'b0));
        @(posedge clock); #1;
        got = obs_now(); exp = sbq.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_fixed_prio();
        obs_t got, exp;
        cfg_rr_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = (k < 2) ? 4'b0110 : 4'b0000;
            sbq.push_back(mk_exp((k < 2) ? 1 : -1, 1'b0));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL fixed_prio k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_rr_rotate();
        obs_t got, exp;
        do_reset();
        cfg_rr_mode = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cfg_timeout_we = (k == 0);
            cfg_timeout    = 8'd3;
            req = (k == 0 || k == 16) ? 4'b0000 : 4'b1111;
            if (k == 0 || k == 16) sbq.push_back(mk_exp(-1, 1'b0));
            else sbq.push_back(mk_exp(((k - 1) / 3) % 4, (k > 1) && ((k - 1) % 3 == 0)));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rr_rotate k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        cfg_timeout_we = 1'b0;
    endtask

    // Lone ch2 for 200 cycles, then ch0 competes: pre-emption only once the restarted counter reaches 64.
    task automatic test_single_hold();
        obs_t got, exp;
        cfg_rr_mode = 1'b0;
        cfg_timeout_we = 1'b1; cfg_timeout = 8'd64; req = 4'b0000;
        sbq.push_back(mk_exp(-1, 1'b0));
        @(posedge clock); #1;
        cfg_timeout_we = 1'b0;
        got = obs_now(); exp = sbq.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL hold_cfg got=%h exp=%h", got, exp);
        end
        for (int k = 0; k <= 256; k++) begin
            req = (k < 200) ? 4'b0100 : 4'b0101;
            sbq.push_back((k < 256) ? mk_exp(2, 1'b0) : mk_exp(0, 1'b1));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single_hold k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_handover();
        obs_t got, exp;
        for (int k = 0; k < 2; k++) begin
            req = (k == 0) ? 4'b1000 : 4'b0000;
            sbq.push_back(mk_exp((k == 0) ? 3 : -1, 1'b0));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL handover k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_cfg_write();
        obs_t got, exp;
        cfg_rr_mode = 1'b0;
        for (int k = 0; k <= 43; k++) begin
            req            = (k <= 40) ? 4'b0010 : ((k < 43) ? 4'b0011 : 4'b0000);
            cfg_timeout_we = (k == 41);
            cfg_timeout    = 8'd10;
            if (k <= 41)      sbq.push_back(mk_exp(1, 1'b0));
            else if (k == 42) sbq.push_back(mk_exp(0, 1'b1));
            else              sbq.push_back(mk_exp(-1, 1'b0));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL cfg_write k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        cfg_timeout_we = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        req = 4'b0011;
        sbq.push_back(mk_exp(0, 1'b0));
        @(posedge clock); #1;
        got = obs_now(); exp = sbq.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL async_pre got=%h exp=%h", got, exp);
        end
        #3 reset = 1'b1;
        #1;
        got = obs_now();
        checks++;
        if (got !== mk_exp(-1, 1'b0) || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL async_reset got=%h gid=%0d exp=%h gid=0", got, grant_id, mk_exp(-1, 1'b0));
        end
        @(posedge clock); #1;
        reset = 1'b0;
        // Timeout is back to 64 after reset, not the 10 written earlier.
        for (int k = 0; k <= 65; k++) begin
            req = (k <= 64) ? 4'b0011 : 4'b0000;
            if (k < 64)       sbq.push_back(mk_exp(0, 1'b0));
            else if (k == 64) sbq.push_back(mk_exp(1, 1'b1));
            else              sbq.push_back(mk_exp(-1, 1'b0));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL async_after k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_timeout_zero();
        obs_t got, exp;
        cfg_rr_mode = 1'b0;
        for (int k = 0; k <= 301; k++) begin
            cfg_timeout_we = (k == 0);
            cfg_timeout    = 8'd0;
            req = (k == 0 || k == 301) ? 4'b0000 : 4'b0011;
            sbq.push_back((k == 0 || k == 301) ? mk_exp(-1, 1'b0) : mk_exp(0, 1'b0));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL timeout_zero k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        cfg_timeout_we = 1'b0;
    endtask

    task automatic test_timeout_one();
        obs_t got, exp;
        do_reset();
        cfg_rr_mode = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            cfg_timeout_we = (k == 0);
            cfg_timeout    = 8'd1;
            req = (k == 0 || k == 10) ? 4'b0000 : 4'b0111;
            if (k == 0 || k == 10) sbq.push_back(mk_exp(-1, 1'b0));
            else sbq.push_back(mk_exp((k - 1) % 3, k > 1));
            @(posedge clock); #1;
            got = obs_now(); exp = sbq.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL timeout_one k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        cfg_timeout_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        cfg_timeout_we = 1'b0;
        cfg_timeout    = '0;
        cfg_rr_mode    = 1'b0;
        req            = '0;
        r_wb_proc      = 4'b1010;
        for (int i = 0; i < NCH; i++) begin
            addbus_proc[i*AW +: AW]       = ch_addr(i);
            datawritebus_proc[i*DW +: DW] = ch_dat(i);
        end
        test_reset();
        test_fixed_prio();
        test_rr_rotate();
        test_single_hold();
        test_handover();
        test_cfg_write();
        test_async_reset();
        test_timeout_zero();
        test_timeout_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
